// File: rtl/rom_prefetch_ctrl.sv
// Bus-slave front end for the boot/instruction ROM with a one-word sequential prefetch buffer.
// Define ROM_PREFETCH_EN to enable the prefetch buffer; without it every read takes 2 cycles.
module rom_prefetch_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic              w_req;
    logic [ADDR_W-1:0] r_req_addr;

    assign w_req = !cs_ && !as_;

`ifdef ROM_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_PF} state_t;

    state_t            r_state;
    logic              r_pf_valid;
    logic [ADDR_W-1:0] r_pf_addr;
    logic [DATA_W-1:0] r_pf_data;
    logic [ADDR_W-1:0] w_nxt;
    logic              w_hit;

    assign w_nxt = r_req_addr + ADDR_W'(1);
    assign w_hit = r_pf_valid && (r_pf_addr == addr);

    // WAIT/ISSUE address the word after the demand word so PF can capture it.
    always_comb begin
        rom_addr = addr;
        case (r_state)
            S_WAIT, S_ISSUE: rom_addr = w_nxt;
            default:         rom_addr = addr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            rd_data    <= '0;
            rdy_       <= 1'b1;
            r_pf_valid <= 1'b0;
            r_pf_addr  <= '0;
            r_pf_data  <= '0;
            r_req_addr <= '0;
        end else begin
            rdy_ <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!rw) begin
                            rdy_    <= 1'b0;
                            rd_data <= '0;
                        end else if (w_hit) begin
                            rd_data    <= r_pf_data;
                            rdy_       <= 1'b0;
                            r_req_addr <= addr;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_req_addr <= addr;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    rd_data <= rom_data;
                    rdy_    <= 1'b0;
                    r_state <= S_PF;
                end
                S_ISSUE: r_state <= S_PF;
                S_PF: begin
                    r_pf_data  <= rom_data;
                    r_pf_addr  <= w_nxt;
                    r_pf_valid <= 1'b1;
                    r_state    <= S_IDLE;
                    if (w_req) begin
                        if (!rw) begin
                            rdy_    <= 1'b0;
                            rd_data <= '0;
                        end else if (addr == w_nxt) begin
                            // The prefetched word is on rom_data right now: forward it.
                            rd_data    <= rom_data;
                            rdy_       <= 1'b0;
                            r_req_addr <= addr;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_req_addr <= addr;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t r_state;

    assign rom_addr = (r_state == S_WAIT) ? r_req_addr : addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            rd_data    <= '0;
            rdy_       <= 1'b1;
            r_req_addr <= '0;
        end else begin
            rdy_ <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!rw) begin
                            rdy_    <= 1'b0;
                            rd_data <= '0;
                        end else begin
                            r_req_addr <= addr;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    rd_data <= rom_data;
                    rdy_    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rom_prefetch_ctrl.sv
// Self-checking bench for rom_prefetch_ctrl: directed plan plus random read/write traffic
// against a buffer-level reference model (hit iff buffered word is the next sequential one).
module tb_rom_prefetch_ctrl;

`ifdef ROM_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [10:0] addr;
    logic [31:0] rd_data;
    logic        rdy_;
    logic [10:0] rom_addr;
    logic [31:0] rom_data;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit          m_valid;
    logic [10:0] m_addr;
    logic [31:0] m_last;

    rom_prefetch_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .rd_data(rd_data), .rdy_(rdy_), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM macro: mem[i] = 0xA000_0000 + i, one-cycle registered read
    always_ff @(posedge clk) rom_data <= 32'hA000_0000 + {21'd0, rom_addr};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, rdy_}, 32'd1);
        chk("rst_data", rd_data, 32'd0);
        reset = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_last  = '0;
    endtask

    // One request, issued the cycle after the previous response.
    task automatic do_op(input bit is_rd, input logic [10:0] a);
        bit          hit;
        int          exp_lat;
        logic [31:0] exp_data;
        int          lat;
        bit          got;
        @(posedge clk);
        #1;
        chk("rdy_idle", {31'd0, rdy_}, 32'd1);
        chk("hold", rd_data, m_last);
        hit      = PF_EN && m_valid && (m_addr == a);
        exp_lat  = (!is_rd || hit) ? 1 : 2;
        exp_data = is_rd ? (32'hA000_0000 + {21'd0, a}) : 32'd0;
        if (is_rd) begin
            m_valid = 1'b1;
            m_addr  = a + 11'd1;
        end
        m_last = exp_data;
        cs_ = 1'b0; as_ = 1'b0; rw = is_rd; addr = a;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(posedge clk);
            #1;
            cs_ = 1'b1; as_ = 1'b1;
            if (rdy_ == 1'b0) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk("rdy_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("latency", lat, exp_lat);
            chk("rd_data", rd_data, exp_data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        do_op(1'b1, 11'h010);
        for (int i = 0; i < 8; i++) do_op(1'b1, 11'h020 + 11'(i));
        do_op(1'b1, 11'h7FF);
        do_op(1'b1, 11'h000);
        do_op(1'b1, 11'h030);
        do_op(1'b1, 11'h031);
        do_op(1'b1, 11'h100);
        do_op(1'b1, 11'h101);
        do_op(1'b0, 11'h040);
        do_op(1'b1, 11'h040);

        // reset while the controller waits on a miss
        do_op(1'b1, 11'h050);
        @(posedge clk);
        #1;
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 11'h200;
        @(posedge clk);
        #1;
        cs_ = 1'b1; as_ = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_wait_rdy", {31'd0, rdy_}, 32'd1);
        chk("rst_wait_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_valid = 1'b0;
        m_last  = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("no_rdy_after_rst", {31'd0, rdy_}, 32'd1);
        end
        do_op(1'b1, 11'h051);

        // random traffic biased toward sequential fetch
        for (int n = 0; n < 80; n++) begin
            int          r;
            logic [10:0] a;
            r = $urandom_range(0, 9);
            a = 11'($urandom);
            if (r < 5)      do_op(1'b1, m_addr);
            else if (r < 7) do_op(1'b1, a);
            else if (r < 8) do_op(1'b0, a);
            else            do_op(1'b1, m_addr - 11'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_prefetch_ctrl.md
Name: rom_prefetch_ctrl

Overview:
- Bus-slave front end for the single-port instruction/boot ROM (sync read, 1-cycle registered latency, `ROM_DEPTH` words of `WordDataBus`).
- Turns AZPR bus read strobes into ROM addresses and returns data with an active-low ready.
- Keeps a one-word sequential prefetch buffer, so linear instruction fetch from ROM hits with 1-cycle latency instead of 2.
- Sits between the bus interconnect (upstream) and the ROM macro (downstream).

Parameters:
- ADDR_W, 11, ROM word-address width. 2^ADDR_W = `ROM_DEPTH`.
- DATA_W, 32, word width (`WordDataBus`).

Ports:
- clk  in  1  system clock; the ROM shares it.
- reset  in  1  asynchronous, active-low reset.
- cs_  in  1  chip select, active low.
- as_  in  1  address strobe, active low; one-cycle pulse per request.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  word address.
- rd_data  out  DATA_W  read data, registered.
- rdy_  out  1  ready, active low, registered one-cycle pulse.
- rom_addr  out  ADDR_W  ROM address, combinational from the FSM.
- rom_data  in  DATA_W  ROM output; valid the cycle after rom_addr is presented.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, rd_data = 0, rdy_ = 1, pf_valid = 0, pf_addr = 0, pf_data = 0, req_addr = 0. Reset mid-transaction abandons the request; no rdy_ is produced.
- req = !cs_ & !as_, sampled at posedge. Requests are honoured only in IDLE and PF. In WAIT/ISSUE they are a protocol violation and are ignored. The master must wait for rdy_ before issuing the next request.
- nxt = req_addr + 1, modulo 2^ADDR_W (0x7FF + 1 = 0x000).
- IDLE: rom_addr = addr.
  - Read, hit (pf_valid & pf_addr == addr): rd_data <= pf_data, rdy_ <= 0, req_addr <= addr, go to ISSUE.
  - Read, miss: req_addr <= addr, go to WAIT.
  - Write: rdy_ <= 0, rd_data <= 0, stay in IDLE; ROM and buffer untouched.
- WAIT: rom_addr = nxt. rom_data holds the demand word: rd_data <= rom_data, rdy_ <= 0, go to PF.
- ISSUE: rom_addr = nxt, go to PF.
- PF: rom_addr = addr. rom_data holds the word at nxt; always pf_data <= rom_data, pf_addr <= nxt, pf_valid <= 1.
  - No request: go to IDLE.
  - Read with addr == nxt: forward rd_data <= rom_data, rdy_ <= 0, req_addr <= addr, go to ISSUE.
  - Read, other address: req_addr <= addr, go to WAIT (ROM already addressed this cycle).
  - Write: rdy_ <= 0, rd_data <= 0, go to IDLE.
- rdy_ is low for exactly one cycle per accepted request. rd_data holds its value until the next response.
- Latency (request cycle = c0, rdy_ low in cN):
  - Miss: N = 2.
  - Hit: N = 1.
  - Streaming sequential reads: one word per 2 cycles, every access after the first is a hit.

Optional Feature:
- Macro: ROM_PREFETCH_EN.
- Defined: behaviour as above.
- Undefined:
  - States are IDLE and WAIT only; pf_* registers are removed.
  - rom_addr = addr in IDLE and req_addr in WAIT.
  - Every read takes 2 cycles: WAIT captures rom_data, pulses rdy_, returns to IDLE.
  - Writes are unchanged.

Test Plan:
- ROM image mem[i] = 0xA000_0000 + i. Reset, then read addr 0x010 → rdy_ low in c2, rd_data = 0xA000_0010. pf_addr = 0x011, pf_valid = 1.
- Reads 0x020..0x027 issued back-to-back on rdy_ → first takes 2 cycles, remaining seven take 1 cycle each, data 0xA000_0020..0xA000_0027 in order.
- Read 0x7FF, then 0x000 → second access hits via wrap, rd_data = 0xA000_0000 with 1-cycle latency.
- Read 0x030 then 0x100 (non-sequential, issued in PF) → 0x100 misses, 2-cycle latency, rd_data = 0xA000_0100, pf_addr = 0x101.
- Write to 0x040 → rdy_ pulse in c1, rd_data = 0. A following read of 0x040 returns 0xA000_0040.
- Assert reset in WAIT → no rdy_ pulse, pf_valid = 0. A post-reset read of the previously buffered address misses with 2-cycle latency.
- Macro undefined → every test above sees 2-cycle latency with identical data.
